// File: rtl/ocl_axil_pkg.sv
// Shared types and constants for the OCL AXI4-Lite initiator and its bench.
package ocl_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_A,
        ST_RD_R,
        ST_RSP
    } axil_state_e;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } axil_cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } axil_rsp_t;

endpackage

// File: rtl/ocl_axil_timer.sv
// Clearable/loadable up-counter with a >= terminal-count flag, optionally saturating.
module ocl_axil_timer #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [1:0]       step,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        sum     = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, step};
        cnt_nxt = (SATURATE && sum[CNT_W]) ? '1 : sum[CNT_W-1:0];
    end

    assign tc = (cnt >= tc_val);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ocl_axil_master.sv
// Single-outstanding AXI4-Lite initiator: valid/ready command stream in,
// one response per command out, with per-transaction timeout and stray-beat drain.
module ocl_axil_master
    import ocl_axil_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    output logic [CNT_W-1:0]  stray_cnt
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    axil_state_e       state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done_q, w_done_q;
    axil_rsp_t         rsp_q;

    logic             idle_live, accept, busy;
    logic             aw_hs, w_hs, aw_fin, w_fin;
    logic             to_tc, to_hit;
    logic             cap_b, cap_r, cap_to;
    logic [CNT_W-1:0] to_cnt;
    logic [1:0]       stray_step;
    logic             stray_full;

    // run_q keeps cmd_ready and the drain readies low while reset is held
    assign idle_live = (state_q == ST_IDLE) && run_q;
    assign accept    = idle_live && cmd_valid;
    assign busy      = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                       (state_q == ST_RD_A) || (state_q == ST_RD_R);

    assign cmd_ready   = idle_live;
    assign m_awvalid   = (state_q == ST_WR) && !aw_done_q;
    assign m_wvalid    = (state_q == ST_WR) && !w_done_q;
    assign m_arvalid   = (state_q == ST_RD_A);
    assign m_bready    = idle_live || (state_q == ST_WR_B);
    assign m_rready    = idle_live || (state_q == ST_RD_R);
    assign m_awaddr    = addr_q;
    assign m_araddr    = addr_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign rsp_valid   = (state_q == ST_RSP);
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_resp    = rsp_q.resp;
    assign rsp_timeout = rsp_q.timeout;

    assign aw_hs  = m_awvalid && m_awready;
    assign w_hs   = m_wvalid && m_wready;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;
    assign to_hit = TO_EN && to_tc;

    // a completing handshake is checked before the timeout so it always wins
    always_comb begin
        state_d = state_q;
        cap_b   = 1'b0;
        cap_r   = 1'b0;
        cap_to  = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = cmd_write ? ST_WR : ST_RD_A;
            ST_WR: begin
                if (aw_fin && w_fin) state_d = ST_WR_B;
                else if (to_hit) begin state_d = ST_RSP; cap_to = 1'b1; end
            end
            ST_WR_B: begin
                if (m_bvalid) begin state_d = ST_RSP; cap_b = 1'b1; end
                else if (to_hit) begin state_d = ST_RSP; cap_to = 1'b1; end
            end
            ST_RD_A: begin
                if (m_arready) state_d = ST_RD_R;
                else if (to_hit) begin state_d = ST_RSP; cap_to = 1'b1; end
            end
            ST_RD_R: begin
                if (m_rvalid) begin state_d = ST_RSP; cap_r = 1'b1; end
                else if (to_hit) begin state_d = ST_RSP; cap_to = 1'b1; end
            end
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rsp_q     <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (cap_b) begin
                rsp_q.rdata   <= '0;
                rsp_q.resp    <= m_bresp;
                rsp_q.timeout <= 1'b0;
            end else if (cap_r) begin
                rsp_q.rdata   <= m_rdata;
                rsp_q.resp    <= m_rresp;
                rsp_q.timeout <= 1'b0;
            end else if (cap_to) begin
                rsp_q.rdata   <= '0;
                rsp_q.resp    <= AXI_SLVERR;
                rsp_q.timeout <= 1'b1;
            end
        end
    end

    // timer freezes at terminal count so a late handshake still sees tc next state
    ocl_axil_timer #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b0)
    ) u_to_timer (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .clr         (accept),
        .load        (1'b0),
        .load_val    ('0),
        .en          (busy && !to_tc),
        .step        (2'd1),
        .tc_val      (TO_LAST),
        .cnt         (to_cnt),
        .tc          (to_tc)
    );

    assert property (@(posedge clk_main_a0) disable iff (!rst_main_n)
        !TO_EN || (to_cnt <= TO_LAST));

    assign stray_step = idle_live ? ({1'b0, m_bvalid} + {1'b0, m_rvalid}) : 2'd0;

    ocl_axil_timer #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b1)
    ) u_stray_cnt (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .clr         (1'b0),
        .load        (1'b0),
        .load_val    ('0),
        .en          (!stray_full),
        .step        (stray_step),
        .tc_val      ('1),
        .cnt         (stray_cnt),
        .tc          (stray_full)
    );

endmodule

// File: tb/tb_ocl_axil_master.sv
// Scoreboard bench for ocl_axil_master against a hand-driven AXI-Lite slave.
module tb_ocl_axil_master;
    import ocl_axil_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 1'b0, m_bready;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic        m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
    logic [31:0] m_rdata = '0;
    logic [15:0] stray_cnt;

    always #5 clk_main_a0 = ~clk_main_a0;

    ocl_axil_master #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk_main_a0 (clk_main_a0), .rst_main_n (rst_main_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout),
        .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
        .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wdata (m_wdata), .m_wstrb (m_wstrb),
        .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bresp (m_bresp),
        .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr (m_araddr),
        .m_rvalid (m_rvalid), .m_rready (m_rready), .m_rdata (m_rdata), .m_rresp (m_rresp),
        .stray_cnt (stray_cnt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    axil_rsp_t   sb_q[$];
    axil_rsp_t   sb_exp;
    logic [15:0] exp_stray = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic axil_rsp_t mk_rsp(input logic [31:0] rdata, input logic [1:0] resp,
                                         input logic timeout);
        axil_rsp_t r;
        r.rdata   = rdata;
        r.resp    = resp;
        r.timeout = timeout;
        return r;
    endfunction

    // response monitor samples 1ns before each rising edge
    always begin
        @(negedge clk_main_a0);
        #4;
        if (rst_main_n && rsp_valid && rsp_ready) begin
            chk("sb_pending", 64'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, sb_exp.rdata);
                chk("rsp_resp", rsp_resp, sb_exp.resp);
                chk("rsp_timeout", rsp_timeout, sb_exp.timeout);
            end
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk_main_a0);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!cmd_ready && n < 64) begin
            @(negedge clk_main_a0);
            n++;
        end
        chk("idle_reached", cmd_ready, 1);
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input axil_rsp_t exp, input bit push);
        int unsigned n = 0;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 64) begin
            @(negedge clk_main_a0);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        if (push) sb_q.push_back(exp);
        @(negedge clk_main_a0);
        cmd_valid = 1'b0;
    endtask

    task automatic skew_write(input bit aw_first, input logic [1:0] br);
        send_cmd(1'b1, aw_first ? 32'h14 : 32'h18, 32'hA5A5_0001, 4'h3, mk_rsp('0, br, 1'b0), 1'b1);
        if (aw_first) m_awready = 1'b1; else m_wready = 1'b1;
        cyc(1);
        m_awready = 1'b0;
        m_wready  = 1'b0;
        chk("skew_first_drop", aw_first ? m_awvalid : m_wvalid, 0);
        chk("skew_second_held", aw_first ? m_wvalid : m_awvalid, 1);
        cyc(2);
        chk("skew_second_held_late", aw_first ? m_wvalid : m_awvalid, 1);
        if (aw_first) m_wready = 1'b1; else m_awready = 1'b1;
        cyc(1);
        m_awready = 1'b0;
        m_wready  = 1'b0;
        chk("skew_valids_low", {m_awvalid, m_wvalid}, 2'b00);
        chk("skew_bready", m_bready, 1);
        m_bvalid = 1'b1;
        m_bresp  = br;
        cyc(1);
        m_bvalid = 1'b0;
        m_bresp  = '0;
        chk("skew_rsp_valid", rsp_valid, 1);
        cyc(1);
        chk("skew_one_b", stray_cnt, exp_stray);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;

        // reset state
        cyc(2);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, rsp_valid}, 4'b0000);
        chk("rst_readies", {m_bready, m_rready}, 2'b00);
        chk("rst_stray", stray_cnt, 0);
        rst_main_n = 1'b1;
        cyc(1);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // zero-wait write
        m_awready = 1'b1;
        m_wready  = 1'b1;
        send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, mk_rsp('0, AXI_OKAY, 1'b0), 1'b1);
        chk("wr_aw_w_same_cycle", {m_awvalid, m_wvalid}, 2'b11);
        chk("wr_awaddr", m_awaddr, 32'h0000_0010);
        chk("wr_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", m_wstrb, 4'hF);
        cyc(1);
        m_awready = 1'b0;
        m_wready  = 1'b0;
        chk("wr_valids_drop", {m_awvalid, m_wvalid}, 2'b00);
        chk("wr_bready", m_bready, 1);
        m_bvalid = 1'b1;
        cyc(1);
        m_bvalid = 1'b0;
        wait_idle();
        chk("wr_stray", stray_cnt, exp_stray);

        // skewed ready, both orders; second one returns SLVERR from the slave
        skew_write(1'b1, AXI_OKAY);
        skew_write(1'b0, AXI_SLVERR);

        // read with arready delay and response back-pressure
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h0000_0020, '0, '0, mk_rsp(32'h1234_5678, AXI_OKAY, 1'b0), 1'b1);
        chk("rd_arvalid", m_arvalid, 1);
        chk("rd_araddr", m_araddr, 32'h0000_0020);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rd_wait_cmd_ready", cmd_ready, 0);
            chk("rd_wait_arvalid", m_arvalid, 1);
        end
        m_arready = 1'b1;
        cyc(1);
        m_arready = 1'b0;
        chk("rd_arvalid_drop", m_arvalid, 0);
        chk("rd_rready", m_rready, 1);
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        m_rresp  = AXI_OKAY;
        cyc(1);
        m_rvalid = 1'b0;
        m_rdata  = 32'hFFFF_FFFF;
        m_rresp  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk("rd_bp_rsp_valid", rsp_valid, 1);
            chk("rd_bp_rdata_stable", rsp_rdata, 32'h1234_5678);
            chk("rd_bp_cmd_ready", cmd_ready, 0);
            cyc(1);
        end
        rsp_ready = 1'b1;
        cyc(1);
        m_rresp = AXI_OKAY;
        wait_idle();

        // timeout: slave never returns B
        m_awready = 1'b1;
        m_wready  = 1'b1;
        send_cmd(1'b1, 32'h0000_0030, 32'h1111_2222, 4'hF, mk_rsp('0, AXI_SLVERR, 1'b1), 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk_main_a0);
            n++;
            if (n == 1) begin
                m_awready = 1'b0;
                m_wready  = 1'b0;
            end
        end
        chk("to_latency", n, TO);
        chk("to_valids_low", {m_awvalid, m_wvalid, m_arvalid, m_bready}, 4'b0000);
        chk("to_flag", rsp_timeout, 1);
        wait_idle();
        m_bvalid = 1'b1;
        cyc(1);
        m_bvalid = 1'b0;
        exp_stray = exp_stray + 16'd1;
        chk("to_late_b_stray", stray_cnt, exp_stray);
        m_bvalid = 1'b1;
        m_rvalid = 1'b1;
        cyc(1);
        m_bvalid = 1'b0;
        m_rvalid = 1'b0;
        exp_stray = exp_stray + 16'd2;
        chk("stray_b_and_r", stray_cnt, exp_stray);

        // race: R arrives on the terminal-count cycle
        m_arready = 1'b1;
        send_cmd(1'b0, 32'h0000_0040, '0, '0, mk_rsp(32'hCAFE_F00D, AXI_OKAY, 1'b0), 1'b1);
        cyc(1);
        m_arready = 1'b0;
        cyc(TO - 2);
        chk("race_rready_at_tc", m_rready, 1);
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_F00D;
        cyc(1);
        m_rvalid = 1'b0;
        chk("race_rsp_valid", rsp_valid, 1);
        chk("race_no_timeout", rsp_timeout, 0);
        wait_idle();
        chk("race_stray", stray_cnt, exp_stray);

        // reset in the middle of a write
        send_cmd(1'b1, 32'h0000_0050, 32'h55AA_55AA, 4'hF, mk_rsp('0, AXI_OKAY, 1'b0), 1'b0);
        chk("rst_mid_awvalid_pre", m_awvalid, 1);
        #2;
        rst_main_n = 1'b0;
        #1;
        chk("rst_mid_valids", {m_awvalid, m_wvalid}, 2'b00);
        cyc(1);
        rst_main_n = 1'b1;
        exp_stray  = '0;
        cyc(2);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_stray", stray_cnt, exp_stray);
        chk("rst_mid_no_rsp", rsp_valid, 0);

        chk("sb_drained", 64'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
